stream_demux: RTL and testbench

Registered, handshaked successor of the combinational demux. It routes a valid/ready input stream to one of 2**CW output channels, or broadcasts to all of them. Each channel has its own one-entry output buffer, so a stalled channel does not block traffic to the others. It sits between pipeline stages wherever one producer feeds several consumers.

---
 rtl/stream_demux.sv | 77 +++++++
 tb/tb_stream_demux.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered valid/ready demux with per-channel one-entry buffers and broadcast
`timescale 1ns/1ps
module stream_demux #(
    parameter int DW = 1,
    parameter int CW = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DW-1:0]           i,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [CW-1:0]           s,
    input  logic                    bc,
    output logic [DW*(2**CW)-1:0]   o,
    output logic [(2**CW)-1:0]      o_valid,
    input  logic [(2**CW)-1:0]      o_ready
);

    localparam int N = 2**CW;

    // All per-channel vectors below are indexed by channel number k; the
    // external buses put channel 0 in the most significant position.
    logic [DW-1:0] d_q [N];
    logic [DW-1:0] d_d [N];
    logic [N-1:0]  v_q;
    logic [N-1:0]  v_d;
    logic [N-1:0]  rdy_k;
    logic [N-1:0]  free_k;
    logic [N-1:0]  load_k;
    logic          accept;

    always_comb begin
        rdy_k  = '0;
        free_k = '0;
        for (int k = 0; k < N; k++) begin
            rdy_k[k]  = o_ready[N-1-k];
            free_k[k] = !v_q[k] || rdy_k[k];
        end
    end

    // A broadcast waits until every channel can take it, so it is never split.
    always_comb begin
        i_ready = bc ? (&free_k) : free_k[s];
        accept  = i_valid && i_ready;
    end

    always_comb begin
        load_k = '0;
        v_d    = '0;
        for (int k = 0; k < N; k++) begin
            load_k[k] = accept && (bc || (s == CW'(k)));
            v_d[k]    = load_k[k] || (v_q[k] && !rdy_k[k]);
            d_d[k]    = load_k[k] ? i : d_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < N; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < N; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    // Stale data in an empty buffer is masked so idle channels read as zero.
    for (genvar k = 0; k < N; k++) begin : g_out
        assign o[DW*(N-k)-1 -: DW] = v_q[k] ? d_q[k] : '0;
        assign o_valid[N-1-k]      = v_q[k];
    end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed self-checking bench for stream_demux
`timescale 1ns/1ps
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i;
    logic        i_valid;
    logic        i_ready;
    logic [1:0]  s;
    logic        bc;
    logic [31:0] o;
    logic [3:0]  o_valid;
    logic [3:0]  o_ready;

    int checks = 0;
    int errors = 0;

    stream_demux #(.DW(8), .CW(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .s       (s),
        .bc      (bc),
        .o       (o),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        i       = 8'h00;
        i_valid = 1'b0;
        s       = 2'd0;
        bc      = 1'b0;
        o_ready = 4'b0000;
        #12;
        chk("reset_o", o, 32'h0);
        chk("reset_o_valid", {28'h0, o_valid}, 32'h0);
        chk("reset_i_ready", {31'h0, i_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Unicast to channel 2
        i = 8'hA5; s = 2'd2; i_valid = 1'b1;
        #1;
        chk("uni_i_ready", {31'h0, i_ready}, 32'h1);
        step();
        i_valid = 1'b0;
        chk("uni_o", o, 32'h0000A500);
        chk("uni_o_valid", {28'h0, o_valid}, 32'h2);
        step();
        step();
        chk("uni_hold_o", o, 32'h0000A500);
        chk("uni_hold_o_valid", {28'h0, o_valid}, 32'h2);
        o_ready = 4'b0010;
        step();
        o_ready = 4'b0000;
        chk("uni_drain_o_valid", {28'h0, o_valid}, 32'h0);
        chk("uni_drain_o", o, 32'h0);

        // Stalled channel 1 must not block channel 3
        i = 8'h11; s = 2'd1; i_valid = 1'b1;
        step();
        i = 8'h22; s = 2'd1;
        #1;
        chk("iso_blocked_i_ready", {31'h0, i_ready}, 32'h0);
        step();
        chk("iso_blocked_o_valid", {28'h0, o_valid}, 32'h4);
        chk("iso_blocked_o", o, 32'h00110000);
        i = 8'h33; s = 2'd3;
        #1;
        chk("iso_other_i_ready", {31'h0, i_ready}, 32'h1);
        step();
        i_valid = 1'b0;
        chk("iso_o_valid", {28'h0, o_valid}, 32'h5);
        chk("iso_o", o, 32'h00110033);
        o_ready = 4'b1111;
        step();
        o_ready = 4'b0000;
        chk("iso_drain_o_valid", {28'h0, o_valid}, 32'h0);

        // Full throughput on channel 0
        o_ready = 4'b1000;
        for (int w = 1; w <= 16; w++) begin
            i = 8'(w); s = 2'd0; i_valid = 1'b1;
            #1;
            chk($sformatf("tput_i_ready_%0d", w), {31'h0, i_ready}, 32'h1);
            step();
            chk($sformatf("tput_b0_%0d", w), {24'h0, o[31:24]}, w);
            chk($sformatf("tput_v0_%0d", w), {28'h0, o_valid}, 32'h8);
        end
        i_valid = 1'b0;
        step();
        chk("tput_end_o_valid", {28'h0, o_valid}, 32'h0);
        o_ready = 4'b0000;

        // Broadcast blocked by stalled channel 2, then released
        i = 8'h77; s = 2'd2; i_valid = 1'b1;
        step();
        i = 8'h3C; s = 2'd1; bc = 1'b1;
        #1;
        chk("bc_blocked_i_ready", {31'h0, i_ready}, 32'h0);
        step();
        chk("bc_blocked_o_valid", {28'h0, o_valid}, 32'h2);
        chk("bc_blocked_o", o, 32'h00007700);
        o_ready = 4'b0010;
        #1;
        chk("bc_release_i_ready", {31'h0, i_ready}, 32'h1);
        step();
        i_valid = 1'b0; bc = 1'b0; o_ready = 4'b0000;
        chk("bc_o", o, 32'h3C3C3C3C);
        chk("bc_o_valid", {28'h0, o_valid}, 32'hF);

        // Asynchronous reset pulse with all buffers full
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", {28'h0, o_valid}, 32'h0);
        chk("midrst_o", o, 32'h0);
        chk("midrst_i_ready", {31'h0, i_ready}, 32'h1);
        rst_n = 1'b1;
        step();
        i = 8'h5A; s = 2'd3; i_valid = 1'b1;
        #1;
        chk("post_i_ready", {31'h0, i_ready}, 32'h1);
        step();
        i_valid = 1'b0;
        chk("post_o", o, 32'h0000005A);
        chk("post_o_valid", {28'h0, o_valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
